// File: rtl/apb_check_slave_if.sv
// APB completer-side bus bundle for apb_check_slave: select/enable/write/data in,
// ready and 1-bit parity result out.
interface apb_check_slave_if #(
  parameter int m = 8
) ();
  logic         PSEL;
  logic         PENABLE;
  logic         PWRITE;
  logic [m-1:0] PWDATA;
  logic         PREADY;
  logic         PRDATA;

  modport master (
    output PSEL, PENABLE, PWRITE, PWDATA,
    input  PREADY, PRDATA
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PWDATA,
    output PREADY, PRDATA
  );
endinterface

// File: rtl/apb_check_slave.sv
// APB completer: writes fill a DEPTH-entry FIFO drained by a valid/taken consumer,
// reads return head parity. Define APB_CHECK_WAIT_EN to insert WAIT_CYCLES wait states.
module apb_check_slave #(
  parameter int m           = 8,
  parameter int DEPTH       = 4,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                       PCLK,
  input  logic                       PRESET,
  apb_check_slave_if.slave           apb,
  output logic [m-1:0]               o_data,
  output logic                       o_data_valid,
  input  logic                       i_data_taken,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_param
    $error("apb_check_slave: DEPTH must be a power of two >= 2 and WAIT_CYCLES in 0..15");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_READY = 2'd2
  } state_t;

  state_t        state;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [m-1:0]  mem [DEPTH];
  logic [m-1:0]  head;
  logic          full;
  logic          empty;
  logic          ready;
  logic          xfer_done;
  logic          push;
  logic          pop;

`ifdef APB_CHECK_WAIT_EN
  logic [3:0]    wait_cnt;
`endif

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign head      = mem[rd_ptr];

  // Ready depends only on registered state, the registered occupancy and PWRITE.
  assign ready     = (state == ST_READY) && (!apb.PWRITE || !full);
  assign xfer_done = apb.PSEL && apb.PENABLE && ready;
  assign push      = xfer_done && apb.PWRITE;
  assign pop       = i_data_taken && !empty;

  assign apb.PREADY  = ready;
  assign apb.PRDATA  = ready && !apb.PWRITE && !empty && !(^head);
  assign o_data      = empty ? '0 : head;
  assign o_data_valid = !empty;
  assign o_count     = count;

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      state <= ST_IDLE;
`ifdef APB_CHECK_WAIT_EN
      wait_cnt <= '0;
`endif
    end else begin
      unique case (state)
        ST_IDLE: begin
          // A setup phase is PSEL without PENABLE; a bare PENABLE is ignored.
          if (apb.PSEL && !apb.PENABLE) begin
`ifdef APB_CHECK_WAIT_EN
            if (WAIT_CYCLES == 0) begin
              state <= ST_READY;
            end else begin
              state    <= ST_WAIT;
              wait_cnt <= 4'(WAIT_CYCLES);
            end
`else
            state <= ST_READY;
`endif
          end
        end
`ifdef APB_CHECK_WAIT_EN
        ST_WAIT: begin
          if (!apb.PSEL) begin
            state <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
            if (wait_cnt <= 4'd1) state <= ST_READY;
          end
        end
`endif
        ST_READY: begin
          if (!apb.PSEL || xfer_done) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // ---- FIFO control: pointers and occupancy ----
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // ---- FIFO storage: data only, no reset ----
  always_ff @(posedge PCLK) begin
    if (push) mem[wr_ptr] <= apb.PWDATA;
  end
endmodule

// File: tb/tb_apb_check_slave.sv
// Self-checking bench for apb_check_slave: directed vector table, hand-written
// back-pressure / reset / protocol sequences, and randomized traffic against a queue model.
`timescale 1ns/1ps
module tb_apb_check_slave;
  localparam int M           = 8;
  localparam int DEPTH       = 4;
  localparam int WAIT_CYCLES = 1;
`ifdef APB_CHECK_WAIT_EN
  localparam int NW = WAIT_CYCLES;
`else
  localparam int NW = 0;
`endif

  localparam int OP_W = 0;
  localparam int OP_R = 1;
  localparam int OP_P = 2;

  typedef struct {
    int         op;
    logic [7:0] d;
    logic       exp_prdata;
    logic [7:0] exp_head;
    logic       exp_valid;
    logic [2:0] exp_count;
  } vec_t;

  logic       PCLK = 1'b0;
  logic       PRESET = 1'b0;
  logic [7:0] o_data;
  logic       o_data_valid;
  logic       i_data_taken;
  logic [2:0] o_count;

  int checks = 0;
  int errors = 0;

  apb_check_slave_if #(.m(M)) apb ();

  apb_check_slave #(.m(M), .DEPTH(DEPTH), .WAIT_CYCLES(WAIT_CYCLES)) dut (
    .PCLK         (PCLK),
    .PRESET       (PRESET),
    .apb          (apb.slave),
    .o_data       (o_data),
    .o_data_valid (o_data_valid),
    .i_data_taken (i_data_taken),
    .o_count      (o_count)
  );

  always #5 PCLK = ~PCLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: FIFO contents as a queue, parity rule from bit count.
  logic [7:0] q[$];

  function automatic int model_prdata();
    if (q.size() == 0) return 0;
    return ($countones(q[0]) % 2 == 0) ? 1 : 0;
  endfunction

  function automatic int model_head();
    return (q.size() == 0) ? 0 : int'(q[0]);
  endfunction

  task automatic model_pop();
    if (q.size() > 0) void'(q.pop_front());
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_count"}, o_count, q.size());
    check({tag, "_valid"}, o_data_valid, (q.size() > 0) ? 1 : 0);
    check({tag, "_head"}, o_data, model_head());
  endtask

  // Full transfer: setup, access until PREADY, complete. Returns wait count and PRDATA.
  task automatic apb_xfer(input logic wr, input logic [7:0] d, input logic tk,
                          output int waits, output logic rd);
    @(posedge PCLK); #1;
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = wr; apb.PWDATA = d; i_data_taken = tk;
    @(posedge PCLK); #1;
    apb.PENABLE = 1'b1;
    waits = 0;
    #1;
    while (apb.PREADY !== 1'b1 && waits < 64) begin
      @(posedge PCLK); #2;
      waits++;
    end
    rd = apb.PRDATA;
    @(posedge PCLK); #1;
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; i_data_taken = 1'b0;
    #1;
  endtask

  task automatic do_pop();
    @(posedge PCLK); #1;
    i_data_taken = 1'b1;
    @(posedge PCLK); #1;
    i_data_taken = 1'b0;
    #1;
  endtask

  vec_t       tbl[$];
  int         waits;
  logic       rd;
  int         exp_rd;
  logic [7:0] d;
  logic       tk;
  int         op;

  initial begin
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0; apb.PWDATA = '0;
    i_data_taken = 1'b0;

    // ---- Reset with random inputs ----
    PRESET = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge PCLK); #1;
      apb.PSEL = 1'($urandom); apb.PENABLE = 1'($urandom); apb.PWRITE = 1'($urandom);
      apb.PWDATA = 8'($urandom); i_data_taken = 1'($urandom);
    end
    #2;
    check("rst_pready", apb.PREADY, 0);
    check("rst_prdata", apb.PRDATA, 0);
    check_outputs("rst");
    @(posedge PCLK); #1;
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; i_data_taken = 1'b0;
    PRESET = 1'b1;
    repeat (3) @(posedge PCLK);
    #2;
    check("idle_pready", apb.PREADY, 0);
    check("idle_prdata", apb.PRDATA, 0);
    check_outputs("idle");

    // ---- Directed vector table ----
    tbl.push_back('{OP_W, 8'hF3, 1'b0, 8'hF3, 1'b1, 3'd1});
    tbl.push_back('{OP_R, 8'h00, 1'b1, 8'hF3, 1'b1, 3'd1});
    tbl.push_back('{OP_P, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0});
    tbl.push_back('{OP_W, 8'h01, 1'b0, 8'h01, 1'b1, 3'd1});
    tbl.push_back('{OP_R, 8'h00, 1'b0, 8'h01, 1'b1, 3'd1});
    tbl.push_back('{OP_P, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0});
    tbl.push_back('{OP_R, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0});
    tbl.push_back('{OP_P, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0});
    tbl.push_back('{OP_W, 8'h10, 1'b0, 8'h10, 1'b1, 3'd1});
    tbl.push_back('{OP_W, 8'h20, 1'b0, 8'h10, 1'b1, 3'd2});
    tbl.push_back('{OP_W, 8'h30, 1'b0, 8'h10, 1'b1, 3'd3});
    tbl.push_back('{OP_W, 8'h40, 1'b0, 8'h10, 1'b1, 3'd4});
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].op == OP_P) begin
        do_pop();
      end else begin
        apb_xfer(tbl[i].op == OP_W, tbl[i].d, 1'b0, waits, rd);
        check($sformatf("vec%0d_waits", i), waits, NW);
        if (tbl[i].op == OP_R) check($sformatf("vec%0d_prdata", i), rd, tbl[i].exp_prdata);
      end
      check($sformatf("vec%0d_count", i), o_count, tbl[i].exp_count);
      check($sformatf("vec%0d_valid", i), o_data_valid, tbl[i].exp_valid);
      check($sformatf("vec%0d_head", i), o_data, tbl[i].exp_head);
    end
    q = '{8'h10, 8'h20, 8'h30, 8'h40};

    // ---- PENABLE without a setup phase is ignored ----
    @(posedge PCLK); #1;
    apb.PSEL = 1'b1; apb.PENABLE = 1'b1; apb.PWRITE = 1'b0; apb.PWDATA = 8'h99;
    for (int i = 0; i < 3; i++) begin
      #1; check("nosetup_pready", apb.PREADY, 0);
      @(posedge PCLK); #1;
    end
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
    #1; check_outputs("nosetup");

    // ---- Write into a full FIFO, released by one pop ----
    @(posedge PCLK); #1;
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b1; apb.PWDATA = 8'h50;
    @(posedge PCLK); #1;
    apb.PENABLE = 1'b1;
    for (int i = 0; i < NW + 3; i++) begin
      #1; check($sformatf("full_hold%0d", i), apb.PREADY, 0);
      @(posedge PCLK); #1;
    end
    i_data_taken = 1'b1;
    #1; check("full_popcycle_pready", apb.PREADY, 0);
    @(posedge PCLK); #1;
    i_data_taken = 1'b0;
    #1; check("full_after_pop_pready", apb.PREADY, 1);
    check("full_after_pop_prdata", apb.PRDATA, 0);
    @(posedge PCLK); #1;
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
    #1;
    void'(q.pop_front());
    q.push_back(8'h50);
    check_outputs("full_done");
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain%0d_head", i), o_data, model_head());
      do_pop();
      model_pop();
    end
    check_outputs("drained");

    // ---- PWDATA changing mid-transfer: completing-edge value is stored ----
    @(posedge PCLK); #1;
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b1; apb.PWDATA = 8'h11;
    @(posedge PCLK); #1;
    apb.PENABLE = 1'b1; apb.PWDATA = 8'h66;
    waits = 0;
    #1;
    while (apb.PREADY !== 1'b1 && waits < 64) begin
      @(posedge PCLK); #2;
      waits++;
    end
    @(posedge PCLK); #1;
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
    #1;
    check("midchg_waits", waits, NW);
    q.push_back(8'h66);
    check_outputs("midchg");

    // ---- Reset asserted mid-transfer ----
    @(posedge PCLK); #1;
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b1; apb.PWDATA = 8'hAA;
    @(posedge PCLK); #1;
    apb.PENABLE = 1'b1;
    #1; PRESET = 1'b0;
    #1;
    q.delete();
    check("midrst_pready", apb.PREADY, 0);
    check("midrst_prdata", apb.PRDATA, 0);
    check_outputs("midrst");
    @(posedge PCLK); #1;
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
    PRESET = 1'b1;
    #1; check_outputs("midrst_rel");
    apb_xfer(1'b1, 8'h3C, 1'b0, waits, rd);
    check("postrst_waits", waits, NW);
    q.push_back(8'h3C);
    check_outputs("postrst");

    // ---- Randomized traffic against the queue model ----
    for (int n = 0; n < 200; n++) begin
      op = $urandom_range(0, 2);
      d  = 8'($urandom);
      tk = ($urandom_range(0, 3) == 0);
      if (op == OP_W && q.size() == DEPTH) tk = 1'b1;
      if (op == OP_P) begin
        do_pop();
        model_pop();
      end else if (op == OP_W) begin
        apb_xfer(1'b1, d, tk, waits, rd);
        if (tk) for (int e = 0; e < NW + 2; e++) model_pop();
        q.push_back(d);
        check($sformatf("rnd%0d_wr_waits", n), waits, NW);
      end else begin
        apb_xfer(1'b0, d, tk, waits, rd);
        if (tk) for (int e = 0; e < NW + 1; e++) model_pop();
        exp_rd = model_prdata();
        if (tk) model_pop();
        check($sformatf("rnd%0d_rd_waits", n), waits, NW);
        check($sformatf("rnd%0d_prdata", n), rd, exp_rd);
      end
      check_outputs($sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
